mprjram_arbiter: RTL and testbench
==================================

MPRJRAM_ARBITER -- requirements
Module: mprjram_arbiter

Interface
REQ-001 SHALL have parameters: DELAYS, default 10, BRAM wait-state count per access, legal range 1..255.
REQ-002 SHALL have parameter: ADDR_W, default 10, BRAM word-address width (4 KB at default).
REQ-003 SHALL have port: wb_clk_i  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have port: wb_rst_i  in  1  reset, synchronous, active-high.
REQ-005 SHALL have Wishbone slave ports: wbs_cyc_i in 1; wbs_stb_i in 1; wbs_we_i in 1; wbs_sel_i in 4; wbs_adr_i in 32; wbs_dat_i in 32; wbs_ack_o out 1; wbs_dat_o out 32.
REQ-006 SHALL have LA-side requester ports: la_req in 1; la_we in 1; la_adr in ADDR_W; la_wdata in 32; la_gnt out 1 (one-cycle grant pulse); la_rvalid out 1 (one-cycle completion pulse); la_rdata out 32.
REQ-007 SHALL have BRAM ports: bram_en out 1; bram_we out 4; bram_addr out ADDR_W (word address); bram_wdata out 32; bram_rdata in 32.

Function
REQ-008 SHALL use states IDLE, WB_WAIT, WB_ACK, LA_WAIT, LA_DONE; one access in flight at a time.
REQ-009 SHALL treat a WB request as wbs_cyc_i & wbs_stb_i sampled in IDLE.
REQ-010 SHALL treat a WB request as in range only when wbs_adr_i[31:24] == 8'h38; BRAM word address = wbs_adr_i[ADDR_W+1:2].
REQ-011 SHALL send an out-of-range WB request IDLE -> WB_ACK with no BRAM access; wbs_dat_o = 0.
REQ-012 SHALL grant by round-robin when WB (in range) and la_req are both asserted in IDLE: requester not served last wins; after reset, WB is treated as served last.
REQ-013 SHALL grant a lone requester immediately.
REQ-014 SHALL, on WB grant at edge t, enter WB_WAIT for exactly DELAYS cycles, enter WB_ACK at t+DELAYS, and hold wbs_ack_o high for exactly that one cycle.
REQ-015 SHALL hold bram_en high and bram_addr/bram_wdata stable for every WB_WAIT cycle.
REQ-016 SHALL assert bram_we = wbs_sel_i on a WB write, only in the first WB_WAIT cycle; bram_we = 0 at all other times.
REQ-017 SHALL capture bram_rdata into wbs_dat_o on the WB_WAIT -> WB_ACK edge for reads; wbs_dat_o is don't-care for writes.
REQ-018 SHALL pulse la_gnt for one cycle on the IDLE -> LA_WAIT edge.
REQ-019 SHALL run LA_WAIT for DELAYS cycles with BRAM driven from la_adr/la_wdata (sampled at grant); bram_we = 4'hF in the first LA_WAIT cycle only when la_we.
REQ-020 SHALL capture bram_rdata into la_rdata and pulse la_rvalid for one cycle in LA_DONE.
REQ-021 SHALL return WB_ACK -> IDLE and LA_DONE -> IDLE unconditionally; a request is not re-sampled in the ACK/DONE cycle.
REQ-022 SHALL abort to IDLE with no ack if wbs_cyc_i falls during WB_WAIT; a write already issued stays committed.
REQ-023 SHALL use a wait counter of 8 bits that is reloaded on every grant and does not wrap mid-access.

Reset
REQ-024 SHALL force, while wb_rst_i is high at a rising edge: state IDLE, counter 0, wbs_ack_o 0, wbs_dat_o 0, la_gnt 0, la_rvalid 0, la_rdata 0, bram_en 0, bram_we 0, bram_addr 0, bram_wdata 0, round-robin pointer = WB-served-last.
REQ-025 SHALL, when reset is asserted mid-access, drop the access with no ack/rvalid; the first post-reset request is serviced normally.

Verification
REQ-026 SHALL cover a WB read: BRAM word 5 = 0x0000003E, WB read 0x38000014 -> ack exactly DELAYS+1 cycles after request, wbs_dat_o = 0x0000003E.
REQ-027 SHALL cover a WB byte write: write 0x38000008, sel 4'b0010, data 0x0000AB00 -> bram_we = 4'b0010 for one cycle; readback shows only byte 1 changed.
REQ-028 SHALL cover simultaneous requests: WB and LA asserted together for three accesses after reset -> grant order LA, WB, LA, with no overlap of bram_en ownership.
REQ-029 SHALL cover an out-of-range access: WB read 0x30000000 -> ack 1 cycle later, data 0, bram_en never high.
REQ-030 SHALL cover an abort: wbs_cyc_i dropped at WB_WAIT cycle 3 -> no ack, IDLE next cycle, and a subsequent LA request is granted.
REQ-031 SHALL cover reset mid-access: wb_rst_i for one cycle during LA_WAIT -> all outputs at reset values next cycle, no la_rvalid, and the next WB read returns correct data.

Source files
------------

// File: rtl/mprjram_arbiter_if.sv
// rtl/mprjram_arbiter_if.sv - Wishbone, LA requester and BRAM signal bundle for mprjram_arbiter
interface mprjram_arbiter_if #(
    parameter int ADDR_W = 10
);
    logic              wbs_cyc_i;
    logic              wbs_stb_i;
    logic              wbs_we_i;
    logic [3:0]        wbs_sel_i;
    logic [31:0]       wbs_adr_i;
    logic [31:0]       wbs_dat_i;
    logic              wbs_ack_o;
    logic [31:0]       wbs_dat_o;

    logic              la_req;
    logic              la_we;
    logic [ADDR_W-1:0] la_adr;
    logic [31:0]       la_wdata;
    logic              la_gnt;
    logic              la_rvalid;
    logic [31:0]       la_rdata;

    logic              bram_en;
    logic [3:0]        bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [31:0]       bram_wdata;
    logic [31:0]       bram_rdata;

    // Arbiter side
    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  la_req, la_we, la_adr, la_wdata,
        input  bram_rdata,
        output wbs_ack_o, wbs_dat_o,
        output la_gnt, la_rvalid, la_rdata,
        output bram_en, bram_we, bram_addr, bram_wdata
    );

    // Requesters and BRAM side
    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output la_req, la_we, la_adr, la_wdata,
        output bram_rdata,
        input  wbs_ack_o, wbs_dat_o,
        input  la_gnt, la_rvalid, la_rdata,
        input  bram_en, bram_we, bram_addr, bram_wdata
    );
endinterface

// File: rtl/mprjram_arbiter.sv
// rtl/mprjram_arbiter.sv - round-robin BRAM arbiter between a Wishbone slave port and an LA requester
module mprjram_arbiter #(
    parameter int DELAYS = 10,
    parameter int ADDR_W = 10
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    mprjram_arbiter_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WB_WAIT = 3'd1,
        WB_ACK  = 3'd2,
        LA_WAIT = 3'd3,
        LA_DONE = 3'd4
    } state_t;

    localparam logic [7:0] DLY = 8'(DELAYS);

    state_t            state, state_n;
    logic [7:0]        cnt, cnt_n;
    logic              last_wb, last_wb_n;

    logic              ack_n;
    logic [31:0]       wb_dat_n;
    logic              gnt_n;
    logic              rvalid_n;
    logic [31:0]       la_rdata_n;
    logic              en_n;
    logic [3:0]        we_n;
    logic [ADDR_W-1:0] addr_n;
    logic [31:0]       wdata_n;

    logic              wb_req, wb_hit, wb_win, la_win;
    logic              unused_adr_bits;

    assign unused_adr_bits = ^bus.wbs_adr_i;

    assign wb_req = bus.wbs_cyc_i & bus.wbs_stb_i;
    assign wb_hit = (bus.wbs_adr_i[31:24] == 8'h38);
    // Contention goes to whoever did not win last time
    assign wb_win = wb_req & (~bus.la_req | ~last_wb);
    assign la_win = bus.la_req & (~wb_req | last_wb);

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        last_wb_n  = last_wb;
        ack_n      = 1'b0;
        wb_dat_n   = bus.wbs_dat_o;
        gnt_n      = 1'b0;
        rvalid_n   = 1'b0;
        la_rdata_n = bus.la_rdata;
        en_n       = bus.bram_en;
        we_n       = 4'h0;
        addr_n     = bus.bram_addr;
        wdata_n    = bus.bram_wdata;

        case (state)
            IDLE: begin
                if (wb_win) begin
                    last_wb_n = 1'b1;
                    cnt_n     = DLY;
                    if (wb_hit) begin
                        state_n = WB_WAIT;
                        en_n    = 1'b1;
                        we_n    = bus.wbs_we_i ? bus.wbs_sel_i : 4'h0;
                        addr_n  = bus.wbs_adr_i[ADDR_W+1:2];
                        wdata_n = bus.wbs_dat_i;
                    end else begin
                        // Outside the BRAM window: acknowledge with zero data, no BRAM cycle
                        state_n  = WB_ACK;
                        ack_n    = 1'b1;
                        wb_dat_n = 32'h0;
                    end
                end else if (la_win) begin
                    last_wb_n = 1'b0;
                    cnt_n     = DLY;
                    state_n   = LA_WAIT;
                    gnt_n     = 1'b1;
                    en_n      = 1'b1;
                    we_n      = bus.la_we ? 4'hF : 4'h0;
                    addr_n    = bus.la_adr;
                    wdata_n   = bus.la_wdata;
                end
            end
            WB_WAIT: begin
                if (!bus.wbs_cyc_i) begin
                    state_n = IDLE;
                    en_n    = 1'b0;
                    cnt_n   = 8'd0;
                end else if (cnt <= 8'd1) begin
                    state_n  = WB_ACK;
                    en_n     = 1'b0;
                    ack_n    = 1'b1;
                    wb_dat_n = bus.bram_rdata;
                    cnt_n    = 8'd0;
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
            WB_ACK: begin
                state_n = IDLE;
            end
            LA_WAIT: begin
                if (cnt <= 8'd1) begin
                    state_n    = LA_DONE;
                    en_n       = 1'b0;
                    rvalid_n   = 1'b1;
                    la_rdata_n = bus.bram_rdata;
                    cnt_n      = 8'd0;
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
            LA_DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                en_n    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state          <= IDLE;
            cnt            <= 8'd0;
            last_wb        <= 1'b1;
            bus.wbs_ack_o  <= 1'b0;
            bus.wbs_dat_o  <= 32'h0;
            bus.la_gnt     <= 1'b0;
            bus.la_rvalid  <= 1'b0;
            bus.la_rdata   <= 32'h0;
            bus.bram_en    <= 1'b0;
            bus.bram_we    <= 4'h0;
            bus.bram_addr  <= '0;
            bus.bram_wdata <= 32'h0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            last_wb        <= last_wb_n;
            bus.wbs_ack_o  <= ack_n;
            bus.wbs_dat_o  <= wb_dat_n;
            bus.la_gnt     <= gnt_n;
            bus.la_rvalid  <= rvalid_n;
            bus.la_rdata   <= la_rdata_n;
            bus.bram_en    <= en_n;
            bus.bram_we    <= we_n;
            bus.bram_addr  <= addr_n;
            bus.bram_wdata <= wdata_n;
        end
    end
endmodule

// File: tb/tb_mprjram_arbiter.sv
// tb/tb_mprjram_arbiter.sv - directed table-driven bench for mprjram_arbiter
module tb_mprjram_arbiter;
    localparam int D  = 4;
    localparam int AW = 10;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] wdat;
        int          exp_lat;
        logic        exp_en;
        logic [3:0]  exp_we;
        logic        chk_dat;
        logic [31:0] exp_dat;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mprjram_arbiter_if #(.ADDR_W(AW)) bus ();

    mprjram_arbiter #(.DELAYS(D), .ADDR_W(AW)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus)
    );

    logic [31:0] mem [0:(1<<AW)-1];

    always @(posedge clk) begin
        if (bus.bram_en) begin
            for (int b = 0; b < 4; b++)
                if (bus.bram_we[b]) mem[bus.bram_addr][8*b +: 8] <= bus.bram_wdata[8*b +: 8];
            bus.bram_rdata <= mem[bus.bram_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic wb_access(input vec_t v, output int lat, output logic [31:0] dat,
                             output logic en_seen, output int we_cnt, output logic [3:0] we_val);
        @(negedge clk);
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = v.we;
        bus.wbs_adr_i = v.adr;
        bus.wbs_sel_i = v.sel;
        bus.wbs_dat_i = v.wdat;
        lat = -1; dat = 32'hx; en_seen = 1'b0; we_cnt = 0; we_val = 4'h0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (bus.bram_en) en_seen = 1'b1;
            if (bus.bram_we != 4'h0) begin
                we_cnt++;
                we_val = bus.bram_we;
            end
            if (bus.wbs_ack_o) begin
                lat = i;
                dat = bus.wbs_dat_o;
                break;
            end
        end
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ctl"}, {24'h0, bus.wbs_ack_o, bus.la_gnt, bus.la_rvalid, bus.bram_en, bus.bram_we}, 32'h0);
        chk({tag, "_wbdat"}, bus.wbs_dat_o, 32'h0);
        chk({tag, "_lardata"}, bus.la_rdata, 32'h0);
        chk({tag, "_addr"}, 32'(bus.bram_addr), 32'h0);
        chk({tag, "_wdata"}, bus.bram_wdata, 32'h0);
    endtask

    vec_t vecs [12];

    initial begin
        int          lat, we_cnt, n, seq, en_cycles, gnt_seen, ack_seen, rv_seen;
        logic [31:0] dat, la_first, wb_mid;
        logic        en_seen;
        logic [3:0]  we_val;

        vecs[0]  = '{1'b1, 32'h3800_0014, 4'hF, 32'h0000_003E, D+1, 1'b1, 4'hF, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 32'h3800_0014, 4'hF, 32'h0,         D+1, 1'b1, 4'h0, 1'b1, 32'h0000_003E};
        vecs[2]  = '{1'b1, 32'h3800_0008, 4'hF, 32'h1122_3344, D+1, 1'b1, 4'hF, 1'b0, 32'h0};
        vecs[3]  = '{1'b1, 32'h3800_0008, 4'h2, 32'h0000_AB00, D+1, 1'b1, 4'h2, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, 32'h3800_0008, 4'hF, 32'h0,         D+1, 1'b1, 4'h0, 1'b1, 32'h1122_AB44};
        vecs[5]  = '{1'b0, 32'h3000_0000, 4'hF, 32'h0,         1,   1'b0, 4'h0, 1'b1, 32'h0};
        vecs[6]  = '{1'b1, 32'h3800_0FFC, 4'hF, 32'hDEAD_BEEF, D+1, 1'b1, 4'hF, 1'b0, 32'h0};
        vecs[7]  = '{1'b0, 32'h3800_0FFC, 4'hF, 32'h0,         D+1, 1'b1, 4'h0, 1'b1, 32'hDEAD_BEEF};
        vecs[8]  = '{1'b1, 32'h3800_0010, 4'hF, 32'h0,         D+1, 1'b1, 4'hF, 1'b0, 32'h0};
        vecs[9]  = '{1'b1, 32'h3800_0010, 4'h9, 32'hAABB_CCDD, D+1, 1'b1, 4'h9, 1'b0, 32'h0};
        vecs[10] = '{1'b1, 32'h0000_0010, 4'hF, 32'h1234_5678, 1,   1'b0, 4'h0, 1'b0, 32'h0};
        vecs[11] = '{1'b0, 32'h3800_0010, 4'hF, 32'h0,         D+1, 1'b1, 4'h0, 1'b1, 32'hAA00_00DD};

        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
        bus.wbs_sel_i = 4'h0; bus.wbs_adr_i = 32'h0; bus.wbs_dat_i = 32'h0;
        bus.la_req = 1'b0; bus.la_we = 1'b0; bus.la_adr = '0; bus.la_wdata = 32'h0;

        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("rst0");
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 12; k++) begin
            wb_access(vecs[k], lat, dat, en_seen, we_cnt, we_val);
            chk($sformatf("v%0d_lat", k), 32'(lat), 32'(vecs[k].exp_lat));
            chk($sformatf("v%0d_en", k), {31'h0, en_seen}, {31'h0, vecs[k].exp_en});
            chk($sformatf("v%0d_wecnt", k), 32'(we_cnt), (vecs[k].exp_we != 4'h0) ? 32'd1 : 32'd0);
            chk($sformatf("v%0d_we", k), {28'h0, we_val}, {28'h0, vecs[k].exp_we});
            if (vecs[k].chk_dat) chk($sformatf("v%0d_dat", k), dat, vecs[k].exp_dat);
        end

        // Simultaneous requests straight after reset: LA first, then WB, then LA
        do_reset();
        @(negedge clk);
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0;
        bus.wbs_adr_i = 32'h3800_0014; bus.wbs_sel_i = 4'hF;
        bus.la_req = 1'b1; bus.la_we = 1'b0; bus.la_adr = 10'd2;
        n = 0; seq = 0; en_cycles = 0; la_first = 32'h0; wb_mid = 32'h0;
        for (int i = 0; i < 200 && n < 3; i++) begin
            @(posedge clk); #1;
            if (bus.bram_en) en_cycles++;
            if (bus.la_rvalid) begin
                if (n == 0) la_first = bus.la_rdata;
                seq = seq * 4 + 1;
                n++;
            end
            if (bus.wbs_ack_o) begin
                wb_mid = bus.wbs_dat_o;
                seq = seq * 4 + 2;
                n++;
            end
        end
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.la_req = 1'b0;
        chk("rr_events", 32'(n), 32'd3);
        chk("rr_order", 32'(seq), 32'd25);
        chk("rr_en_cycles", 32'(en_cycles), 32'(3 * D));
        chk("rr_la_rdata", la_first, 32'h1122_AB44);
        chk("rr_wb_dat", wb_mid, 32'h0000_003E);
        repeat (2) @(posedge clk);

        // Abort: cyc dropped in the third WB_WAIT cycle, then an LA write follows
        @(negedge clk);
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0;
        bus.wbs_adr_i = 32'h3800_0014;
        en_seen = 1'b0;
        for (int i = 0; i < 10 && !en_seen; i++) begin
            @(posedge clk); #1;
            en_seen = bus.bram_en;
        end
        chk("abort_started", {31'h0, en_seen}, 32'd1);
        repeat (2) begin
            @(posedge clk); #1;
        end
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
        bus.la_req = 1'b1; bus.la_we = 1'b1; bus.la_adr = 10'd7; bus.la_wdata = 32'h0000_0055;
        @(posedge clk); #1;
        chk("abort_idle", {30'h0, bus.bram_en, bus.wbs_ack_o}, 32'h0);
        gnt_seen = 0; ack_seen = 0; rv_seen = 0;
        for (int i = 0; i < 40 && rv_seen == 0; i++) begin
            @(posedge clk); #1;
            if (bus.la_gnt) begin
                gnt_seen++;
                bus.la_req = 1'b0;
            end
            if (bus.wbs_ack_o) ack_seen++;
            if (bus.la_rvalid) rv_seen++;
        end
        bus.la_req = 1'b0; bus.la_we = 1'b0;
        chk("abort_la_gnt", 32'(gnt_seen), 32'd1);
        chk("abort_no_ack", 32'(ack_seen), 32'd0);
        chk("abort_la_done", 32'(rv_seen), 32'd1);
        repeat (2) @(posedge clk);

        // Reset pulse during LA_WAIT drops the access
        @(negedge clk);
        bus.la_req = 1'b1; bus.la_we = 1'b0; bus.la_adr = 10'd7;
        gnt_seen = 0;
        for (int i = 0; i < 10 && gnt_seen == 0; i++) begin
            @(posedge clk); #1;
            if (bus.la_gnt) gnt_seen = 1;
        end
        bus.la_req = 1'b0;
        chk("rstmid_gnt", 32'(gnt_seen), 32'd1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk_reset_outputs("rstmid");
        @(negedge clk);
        rst = 1'b0;
        rv_seen = 0;
        repeat (2 * D + 2) begin
            @(posedge clk); #1;
            if (bus.la_rvalid) rv_seen++;
        end
        chk("rstmid_no_rvalid", 32'(rv_seen), 32'd0);
        wb_access('{1'b0, 32'h3800_001C, 4'hF, 32'h0, D+1, 1'b1, 4'h0, 1'b1, 32'h55},
                  lat, dat, en_seen, we_cnt, we_val);
        chk("post_rst_lat", 32'(lat), 32'(D + 1));
        chk("post_rst_dat", dat, 32'h0000_0055);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
